// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared state encoding and defaults for the data-memory arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_t;

  localparam int MAX_WAIT_DEF = 4;
  localparam int LEN_W_DEF    = 4;
  localparam int WAIT_W       = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU MEM-stage, DMA burst and datamem signals around the arbiter
interface dmem_arbiter_if #(
  parameter int LEN_W = 4
);
  logic             cpu_en;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;
  logic             dma_start;
  logic             dma_we;
  logic [31:0]      dma_addr;
  logic [LEN_W-1:0] dma_len;
  logic [31:0]      dma_wdata;
  logic             dma_ack;
  logic [31:0]      dma_rdata;
  logic             dma_rvalid;
  logic             dma_busy;
  logic             dma_done;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic [31:0]      mem_rdata;

  // slave: the arbiter itself
  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  dma_start, dma_we, dma_addr, dma_len, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_ack, dma_rdata, dma_rvalid, dma_busy, dma_done,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output dma_start, dma_we, dma_addr, dma_len, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_ack, dma_rdata, dma_rvalid, dma_busy, dma_done,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_port_mux.sv
// rtl/dmem_port_mux.sv - owner select for the single datamem port
module dmem_port_mux (
  input  logic        dma_sel,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_en & cpu_we;
    if (dma_sel) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares datamem between the MEM stage and a word-burst DMA engine
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input logic           clk,
  input logic           clrn,
  dmem_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ZERO = '0;

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LEN_W-1:0]  remain;
  logic [31:0]       addr_q;
  logic              we_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic              busy_q;
  logic              done_q;

  logic in_burst;
  logic force_beat;
  logic beat;

  // CPU wins unless the DMA has waited MAX_WAIT owned cycles in a row
  assign in_burst   = (state == ST_BURST);
  assign force_beat = (wait_cnt == WAIT_LIM);
  assign beat       = in_burst && !(bus.cpu_en && !force_beat);

  assign bus.dma_ack    = beat;
  assign bus.cpu_stall  = in_burst && bus.cpu_en && force_beat;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_rvalid = rvalid_q;
  assign bus.dma_busy   = busy_q;
  assign bus.dma_done   = done_q;

  dmem_port_mux u_port_mux (
    .dma_sel   (beat),
    .cpu_en    (bus.cpu_en),
    .cpu_we    (bus.cpu_we),
    .cpu_addr  (bus.cpu_addr),
    .cpu_wdata (bus.cpu_wdata),
    .dma_we    (we_q),
    .dma_addr  (addr_q),
    .dma_wdata (bus.dma_wdata),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_we    (bus.mem_we)
  );

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      remain   <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rvalid_q <= beat && !we_q;
      if (beat && !we_q) begin
        rdata_q <= bus.mem_rdata;
      end
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (bus.dma_start) begin
            busy_q <= 1'b1;
            if (bus.dma_len != LEN_ZERO) begin
              state  <= ST_BURST;
              addr_q <= bus.dma_addr & 32'hFFFF_FFFC;
              remain <= bus.dma_len;
              we_q   <= bus.dma_we;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (beat) begin
            wait_cnt <= '0;
            addr_q   <= addr_q + 32'd4;
            remain   <= remain - LEN_ONE;
            if (remain == LEN_ONE) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed table-driven bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam logic [31:0] CA = 32'h0000_0040;
  localparam logic [31:0] CW = 32'hC0C0_C0C0;

  typedef struct {
    logic        ce, cw, st, dw;
    logic [31:0] da;
    logic [3:0]  dl;
    logic [31:0] wd;
    logic        ack, stall, mwe, rv, dn, bz;
    logic [31:0] ma;
    logic [31:0] rd;
  } vec_t;

  logic clk;
  logic clrn;
  int   n_chk;
  int   n_err;
  vec_t vq[$];
  logic [31:0] mem [0:255];

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (clrn) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic ce, cw, st, dw, input logic [31:0] da,
                              input logic [3:0] dl, input logic [31:0] wd,
                              input logic ack, stall, mwe, rv, dn, bz,
                              input logic [31:0] ma, input logic [31:0] rd);
    vec_t v;
    v.ce = ce; v.cw = cw; v.st = st; v.dw = dw; v.da = da; v.dl = dl; v.wd = wd;
    v.ack = ack; v.stall = stall; v.mwe = mwe; v.rv = rv; v.dn = dn; v.bz = bz;
    v.ma = ma; v.rd = rd;
    vq.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    bus.cpu_en    = v.ce;
    bus.cpu_we    = v.cw;
    bus.dma_start = v.st;
    bus.dma_we    = v.dw;
    bus.dma_addr  = v.da;
    bus.dma_len   = v.dl;
    bus.dma_wdata = v.wd;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, ".ack"},    {31'b0, bus.dma_ack},    {31'b0, v.ack});
    chk({tag, ".stall"},  {31'b0, bus.cpu_stall},  {31'b0, v.stall});
    chk({tag, ".mem_we"}, {31'b0, bus.mem_we},     {31'b0, v.mwe});
    chk({tag, ".rvalid"}, {31'b0, bus.dma_rvalid}, {31'b0, v.rv});
    chk({tag, ".done"},   {31'b0, bus.dma_done},   {31'b0, v.dn});
    chk({tag, ".busy"},   {31'b0, bus.dma_busy},   {31'b0, v.bz});
    chk({tag, ".addr"},   bus.mem_addr,            v.ma);
    if (v.rv) chk({tag, ".rdata"}, bus.dma_rdata, v.rd);
    if (v.ack && v.dw == 1'b0 && v.st == 1'b0 && v.mwe) chk({tag, ".wdata"}, bus.mem_wdata, v.wd);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clrn  = 1'b1;
    bus.cpu_addr  = CA;
    bus.cpu_wdata = CW;
    drive('{default: '0});

    // uncontended read, len=3, with starts while busy that must be ignored
    add(0,0,1,0,32'h100,3,0, 0,0,0,0,0,0, CA,0);
    add(0,0,0,0,0,0,0,       1,0,0,0,0,1, 32'h100,0);
    add(0,0,1,1,32'h300,2,0, 1,0,0,1,0,1, 32'h104,32'hA000_0040);
    add(0,0,0,0,0,0,0,       1,0,0,1,0,1, 32'h108,32'hA000_0041);
    add(0,0,1,0,32'h300,2,0, 0,0,0,1,1,1, CA,32'hA000_0042);
    add(0,0,0,0,0,0,0,       0,0,0,0,0,0, CA,0);
    // contended write, len=2, cpu_en held high
    add(1,0,1,1,32'h200,2,0, 0,0,0,0,0,0, CA,0);
    for (int i = 0; i < 4; i++) add(1,0,0,0,0,0,0, 0,0,0,0,0,1, CA,0);
    add(1,0,0,0,0,0,32'h1111_1111, 1,1,1,0,0,1, 32'h200,0);
    for (int i = 0; i < 4; i++) add(1,0,0,0,0,0,0, 0,0,0,0,0,1, CA,0);
    add(1,0,0,0,0,0,32'h2222_2222, 1,1,1,0,0,1, 32'h204,0);
    add(1,0,0,0,0,0,0,       0,0,0,0,1,1, CA,0);
    add(0,0,0,0,0,0,0,       0,0,0,0,0,0, CA,0);
    // gaps in CPU traffic, read len=2
    add(0,0,1,0,32'h180,2,0, 0,0,0,0,0,0, CA,0);
    add(1,1,0,0,0,0,0,       0,0,1,0,0,1, CA,0);
    add(0,0,0,0,0,0,0,       1,0,0,0,0,1, 32'h180,0);
    add(1,0,0,0,0,0,0,       0,0,0,1,0,1, CA,32'hA000_0060);
    add(0,0,0,0,0,0,0,       1,0,0,0,0,1, 32'h184,0);
    add(0,0,0,0,0,0,0,       0,0,0,1,1,1, CA,32'hA000_0061);
    add(0,0,0,0,0,0,0,       0,0,0,0,0,0, CA,0);
    // len=0 write: done only, no memory access
    add(0,0,1,1,32'h140,0,32'h3333_3333, 0,0,0,0,0,0, CA,0);
    add(0,0,0,0,0,0,32'h3333_3333,       0,0,0,0,1,1, CA,0);
    add(0,0,0,0,0,0,0,                   0,0,0,0,0,0, CA,0);
    // unaligned start at the top of the address space wraps to 0
    add(0,0,1,0,32'hFFFF_FFFE,2,0, 0,0,0,0,0,0, CA,0);
    add(0,0,0,0,0,0,0,             1,0,0,0,0,1, 32'hFFFF_FFFC,0);
    add(0,0,0,0,0,0,0,             1,0,0,1,0,1, 32'h0,32'hA000_00FF);
    add(0,0,0,0,0,0,0,             0,0,0,1,1,1, CA,32'hA000_0000);
    add(0,0,0,0,0,0,0,             0,0,0,0,0,0, CA,0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst.busy",   {31'b0, bus.dma_busy},   32'd0);
    chk("rst.done",   {31'b0, bus.dma_done},   32'd0);
    chk("rst.rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
    chk("rst.rdata",  bus.dma_rdata,           32'd0);
    chk("rst.ack",    {31'b0, bus.dma_ack},    32'd0);
    chk("rst.stall",  {31'b0, bus.cpu_stall},  32'd0);
    @(negedge clk);
    clrn = 1'b0;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("v%0d", i));

    chk("mem.w0",   mem[8'h80], 32'h1111_1111);
    chk("mem.w1",   mem[8'h81], 32'h2222_2222);
    chk("mem.len0", mem[8'h50], 32'hA000_0050);
    chk("mem.cpu",  mem[8'h10], CW);

    // reset during beat 2 of a len=4 read
    vq.delete();
    add(0,0,1,0,32'h100,4,0, 0,0,0,0,0,0, CA,0);
    add(0,0,0,0,0,0,0,       1,0,0,0,0,1, 32'h100,0);
    add(0,0,0,0,0,0,0,       1,0,0,1,0,1, 32'h104,32'hA000_0040);
    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("r%0d", i));
    clrn = 1'b1;
    #1;
    chk("mid.busy",   {31'b0, bus.dma_busy},   32'd0);
    chk("mid.ack",    {31'b0, bus.dma_ack},    32'd0);
    chk("mid.rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
    chk("mid.rdata",  bus.dma_rdata,           32'd0);
    chk("mid.done",   {31'b0, bus.dma_done},   32'd0);
    @(negedge clk);
    clrn = 1'b0;

    vq.delete();
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0,0, 0,0,0,0,0,0, CA,0);
    add(0,0,1,0,32'h10,1,0, 0,0,0,0,0,0, CA,0);
    add(0,0,0,0,0,0,0,      1,0,0,0,0,1, 32'h10,0);
    add(0,0,0,0,0,0,0,      0,0,0,1,1,1, CA,32'hA000_0004);
    add(0,0,0,0,0,0,0,      0,0,0,0,0,0, CA,0);
    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("p%0d", i));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
